// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment scanner.
// A prescaler divides clk into one slot per digit. Each slot selects one
// digit (active-low anode) and drives its hex glyph plus decimal point.
// The data and dp inputs are captured into shadow registers on a load
// strobe, so the caller can update them at any time without tearing a frame.
module seg_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int SCAN_DIV       = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  en,
    input  logic                  lz_blank,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    // Reject parameter values the scanner cannot represent.
    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("seg_scan_driver: DIGITS must be in 1..8");
        end
        if (SCAN_DIV < 2) begin : g_bad_div
            $error("seg_scan_driver: SCAN_DIV must be >= 2");
        end
        if (SEG_ACTIVE_LOW != 0 && SEG_ACTIVE_LOW != 1) begin : g_bad_pol
            $error("seg_scan_driver: SEG_ACTIVE_LOW must be 0 or 1");
        end
    endgenerate

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   data_q, data_d;
    logic [DIGITS-1:0]     dp_q, dp_d;
    logic                  frame_done_q, frame_done_d;
    logic [7:0]            seg_q, seg_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  tick;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign tick = (presc_q == PW'(SCAN_DIV - 1));

    // Prescaler, digit index, frame pulse and shadow capture.
    always_comb begin
        presc_d      = tick ? '0 : presc_q + PW'(1);
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        if (tick) begin
            // With a single digit every tick is both a wrap and a full frame.
            if (idx_q == IW'(DIGITS - 1)) begin
                idx_d        = '0;
                frame_done_d = 1'b1;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
        data_d = load ? data : data_q;
        dp_d   = load ? dp   : dp_q;
    end

    // Output decode from the current index and shadow values; the result
    // is registered, so the pins trail idx/shadow by one cycle.
    always_comb begin
        logic [3:0] nib;
        logic       dp_bit;
        logic       blank;
        logic [DIGITS-1:0] an_sel;
        logic [7:0] seg_hi;
        nib    = 4'h0;
        dp_bit = 1'b0;
        an_sel = '1;
        // Digit 0 is never blanked; others blank only if they and every
        // more-significant nibble are zero.
        blank  = lz_blank && (idx_q != '0);
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib       = data_q[4*k +: 4];
                dp_bit    = dp_q[k];
                an_sel[k] = 1'b0;
            end
            if ((IW'(k) >= idx_q) && (data_q[4*k +: 4] != 4'h0)) begin
                blank = 1'b0;
            end
        end
        seg_hi = {dp_bit, blank ? 7'h00 : hex7(nib)};
        if (!en) begin
            an_d  = '1;
            seg_d = SEG_OFF;
        end else begin
            an_d  = an_sel;
            seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            idx_q        <= '0;
            data_q       <= '0;
            dp_q         <= '0;
            frame_done_q <= 1'b0;
            seg_q        <= SEG_OFF;
            an_q         <= '1;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            data_q       <= data_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIGITS=4, SCAN_DIV=4, active-low seg.
// e_cnt counts rising edges since the last reset release; slot k of a frame
// is visible on the outputs after edges 4k+1 .. 4k+4.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        en = 1'b1;
    logic        lz_blank = 1'b0;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_done;

    int n_checks = 0;
    int n_err = 0;
    int e_cnt = 0;

    seg_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .data       (data),
        .dp         (dp),
        .en         (en),
        .lz_blank   (lz_blank),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e_cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        e_cnt++;
    endtask

    task automatic step_to(input int target);
        while (e_cnt < target) step();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        load     = 1'b0;
        data     = 16'h0;
        dp       = 4'h0;
        en       = 1'b1;
        lz_blank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        e_cnt = 0;
    endtask

    task automatic load_at_first_edge(input logic [15:0] d, input logic [3:0] p);
        data = d;
        dp   = p;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    logic [3:0] exp_an;
    logic [7:0] seg_tab [4];

    initial begin
        // Reset values while held in reset.
        repeat (2) @(posedge clk);
        #1;
        check("rst_seg", seg, 8'hFF);
        check("rst_an", an, 4'hF);
        check("rst_fd", frame_done, 1'b0);

        // Basic scan with zero data: anode walk and frame pulse.
        do_reset();
        for (int e = 1; e <= 32; e++) begin
            step();
            exp_an = ~(4'b0001 << (((e - 1) / 4) % 4));
            check("scan_an", an, exp_an);
            check("scan_seg", seg, 8'hC0);
            check("scan_fd", frame_done, (e == 16 || e == 32) ? 1'b1 : 1'b0);
        end

        // Hex decode with a decimal point on digit 2.
        do_reset();
        load_at_first_edge(16'h1A2F, 4'b0100);
        check("pre_load_seg", seg, 8'hC0);
        seg_tab = '{8'h8E, 8'hA4, 8'h08, 8'hF9};
        for (int k = 0; k < 4; k++) begin
            step_to(4 * k + 2);
            exp_an = ~(4'b0001 << k);
            check("hex_seg", seg, seg_tab[k]);
            check("hex_an", an, exp_an);
        end

        // Leading-zero blanking, 0x0030.
        do_reset();
        lz_blank = 1'b1;
        load_at_first_edge(16'h0030, 4'b0000);
        seg_tab = '{8'hC0, 8'hB0, 8'hFF, 8'hFF};
        for (int k = 0; k < 4; k++) begin
            step_to(4 * k + 2);
            exp_an = ~(4'b0001 << k);
            check("lz30_seg", seg, seg_tab[k]);
            check("lz30_an", an, exp_an);
        end

        // Leading-zero blanking, all zero: only digit 0 lit.
        do_reset();
        lz_blank = 1'b1;
        load_at_first_edge(16'h0000, 4'b0000);
        seg_tab = '{8'hC0, 8'hFF, 8'hFF, 8'hFF};
        for (int k = 0; k < 4; k++) begin
            step_to(4 * k + 2);
            exp_an = ~(4'b0001 << k);
            check("lz00_seg", seg, seg_tab[k]);
            check("lz00_an", an, exp_an);
        end

        // Load coinciding with the first tick (edge 4).
        do_reset();
        step_to(3);
        data = 16'h00B0;
        load = 1'b1;
        step();
        load = 1'b0;
        check("ldtick_old_seg", seg, 8'hC0);
        check("ldtick_old_an", an, 4'b1110);
        step();
        check("ldtick_new_seg", seg, 8'h83);
        check("ldtick_new_an", an, 4'b1101);

        // Display disabled for edges 11..20; scan and frame pulse keep going.
        do_reset();
        step_to(10);
        en = 1'b0;
        for (int e = 11; e <= 20; e++) begin
            step();
            check("dis_an", an, 4'hF);
            check("dis_seg", seg, 8'hFF);
            check("dis_fd", frame_done, (e == 16) ? 1'b1 : 1'b0);
        end
        en = 1'b1;
        step();
        check("resume_an", an, 4'b1101);
        check("resume_seg", seg, 8'hC0);

        // Asynchronous reset mid-slot while digit 2 is shown.
        do_reset();
        load_at_first_edge(16'h1A2F, 4'b0100);
        step_to(10);
        check("pre_arst_an", an, 4'b1011);
        check("pre_arst_seg", seg, 8'h08);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_seg", seg, 8'hFF);
        check("arst_an", an, 4'hF);
        check("arst_fd", frame_done, 1'b0);
        check("arst_data", dut.data_q, 16'h0);
        check("arst_dp", dut.dp_q, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        e_cnt = 0;
        step();
        check("post_arst_seg0", seg, 8'hC0);
        check("post_arst_an0", an, 4'b1110);
        step_to(9);
        check("post_arst_seg2", seg, 8'hC0);
        check("post_arst_an2", an, 4'b1011);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
